// File: rtl/spi_pkg.sv
// Shared SPI definitions: receiver/master FSM state encoding and default frame width.
package spi_pkg;

    localparam int SPI_DATA_W_DEFAULT = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } spi_state_t;

endpackage : spi_pkg

// File: rtl/spi_sync.sv
// N-stage flop chain for bringing an asynchronous single-bit line into the clk_i domain.
module spi_sync #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] r_chain;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[N-2:0], d_i};
        end
    end

    assign q_o = r_chain[N-1];

endmodule : spi_sync

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive-only slave, oversampled by clk_i, with a one-deep valid/ready output holding register.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              sclk_i,
    input  logic              ss_i,
    input  logic              mosi_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              overrun_o,
    output logic              frame_err_o
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic w_sclk_s;
    logic w_ss_s;
    logic w_mosi_s;

    spi_sync #(.N(SYNC_STAGES)) u_sync_sclk (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .d_i     (sclk_i),
        .q_o     (w_sclk_s)
    );

    spi_sync #(.N(SYNC_STAGES)) u_sync_ss (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .d_i     (ss_i),
        .q_o     (w_ss_s)
    );

    spi_sync #(.N(SYNC_STAGES)) u_sync_mosi (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .d_i     (mosi_i),
        .q_o     (w_mosi_s)
    );

    logic r_sclk_d;
    logic r_ss_d;
    logic w_sclk_rise;
    logic w_ss_rise;
    logic w_ss_fall;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_sclk_d <= 1'b0;
            r_ss_d   <= 1'b0;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_ss_d   <= w_ss_s;
        end
    end

    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_ss_rise   = w_ss_s & ~r_ss_d;
    assign w_ss_fall   = ~w_ss_s & r_ss_d;

    spi_state_t        r_state;
    spi_state_t        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic [DATA_W-1:0] w_word;
    logic              w_complete;
    logic              w_frame_err;

    // w_word is the shift register with the current mosi bit folded in; on the last bit it is the whole frame.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_complete   = 1'b0;
        w_frame_err  = 1'b0;
        if (MSB_FIRST) begin
            w_word = {r_shift[DATA_W-2:0], w_mosi_s};
        end else begin
            w_word = {w_mosi_s, r_shift[DATA_W-1:1]};
        end

        // A select rise wins over a coincident sclk rise so a new frame always starts clean.
        if (w_ss_rise) begin
            w_state_next = ST_RECV;
            w_cnt_next   = '0;
            w_shift_next = '0;
        end else if (r_state == ST_RECV) begin
            if (w_ss_fall) begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
                w_shift_next = '0;
                w_frame_err  = (r_cnt != '0);
            end else if (w_sclk_rise) begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next   = '0;
                    w_shift_next = '0;
                    w_complete   = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                    w_shift_next = w_word;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;
        end
    end

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_overrun;
    logic              r_frame_err;

    // A completed frame is only accepted if the holding register is empty or being drained this cycle.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= 1'b0;
            r_frame_err <= w_frame_err;
            if (w_complete) begin
                if (!r_valid || ready_i) begin
                    r_data  <= w_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign busy_o      = (r_state == ST_RECV);
    assign overrun_o   = r_overrun;
    assign frame_err_o = r_frame_err;

endmodule : spi_slave_rx

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: an MSB-first and an LSB-first instance share one SPI bus and are checked against a frame-queue model.
module tb_spi_slave_rx;

    logic       clk_i   = 1'b0;
    logic       arstn_i = 1'b0;
    logic       sclk_i  = 1'b0;
    logic       ss_i    = 1'b0;
    logic       mosi_i  = 1'b0;
    logic       ready_i = 1'b1;

    logic [7:0] data_m, data_l;
    logic       valid_m, valid_l, busy_m, busy_l;
    logic       ovr_m, ovr_l, ferr_m, ferr_l;

    int errors = 0;
    int checks = 0;

    // Model: frames the consumer must see, in order, per instance.
    logic [7:0] q_m[$];
    logic [7:0] q_l[$];
    int exp_ovr = 0;
    int obs_ovr_m = 0, obs_ovr_l = 0, obs_err_m = 0, obs_err_l = 0;
    int valid_cyc_m = 0, valid_cyc_l = 0, hs_m = 0, hs_l = 0;
    int busy_low = 0;
    bit busy_chk = 1'b0;
    logic ovr_prev_m = 1'b0, ovr_prev_l = 1'b0, ferr_prev_m = 1'b0, ferr_prev_l = 1'b0;

    always #5 clk_i = ~clk_i;

    spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk_i       (clk_i),
        .arstn_i     (arstn_i),
        .sclk_i      (sclk_i),
        .ss_i        (ss_i),
        .mosi_i      (mosi_i),
        .data_o      (data_m),
        .valid_o     (valid_m),
        .ready_i     (ready_i),
        .busy_o      (busy_m),
        .overrun_o   (ovr_m),
        .frame_err_o (ferr_m)
    );

    spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(3), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk_i       (clk_i),
        .arstn_i     (arstn_i),
        .sclk_i      (sclk_i),
        .ss_i        (ss_i),
        .mosi_i      (mosi_i),
        .data_o      (data_l),
        .valid_o     (valid_l),
        .ready_i     (ready_i),
        .busy_o      (busy_l),
        .overrun_o   (ovr_l),
        .frame_err_o (ferr_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // First wire bit lands in bit 0 on the LSB-first instance, so its word is the wire byte reversed.
    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    always @(negedge clk_i) begin
        if (arstn_i) begin
            if (valid_m) begin
                valid_cyc_m++;
                if (q_m.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL msb_unexpected_valid: got data_o=%0h required no pending frame", data_m);
                end else begin
                    check("msb_data", data_m, q_m[0]);
                    if (ready_i) begin
                        void'(q_m.pop_front());
                        hs_m++;
                    end
                end
            end
            if (valid_l) begin
                valid_cyc_l++;
                if (q_l.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL lsb_unexpected_valid: got data_o=%0h required no pending frame", data_l);
                end else begin
                    check("lsb_data", data_l, q_l[0]);
                    if (ready_i) begin
                        void'(q_l.pop_front());
                        hs_l++;
                    end
                end
            end
            if (ovr_m) begin
                obs_ovr_m++;
                check("msb_ovr_pulse_width", ovr_prev_m, 1'b0);
            end
            if (ovr_l) begin
                obs_ovr_l++;
                check("lsb_ovr_pulse_width", ovr_prev_l, 1'b0);
            end
            if (ferr_m) begin
                obs_err_m++;
                check("msb_ferr_pulse_width", ferr_prev_m, 1'b0);
            end
            if (ferr_l) begin
                obs_err_l++;
                check("lsb_ferr_pulse_width", ferr_prev_l, 1'b0);
            end
            if (busy_chk && !(busy_m && busy_l)) busy_low++;
        end
        ovr_prev_m  = ovr_m;
        ovr_prev_l  = ovr_l;
        ferr_prev_m = ferr_m;
        ferr_prev_l = ferr_l;
    end

    task automatic ss_begin();
        ss_i = 1'b1;
        #100;
        check("busy_after_ss_rise_msb", busy_m, 1'b1);
        check("busy_after_ss_rise_lsb", busy_l, 1'b1);
    endtask

    task automatic ss_end();
        #100;
        ss_i = 1'b0;
        #100;
        check("busy_after_ss_fall_msb", busy_m, 1'b0);
        check("busy_after_ss_fall_lsb", busy_l, 1'b0);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi_i = v[i];
            #50 sclk_i = 1'b1;
            #50 sclk_i = 1'b0;
        end
    endtask

    // A full frame is dropped only when the consumer is stalled and a frame is already waiting.
    task automatic send_byte(input logic [7:0] v);
        if (!ready_i && q_m.size() != 0) exp_ovr++;
        else q_m.push_back(v);
        if (!(!ready_i && q_l.size() != 0)) q_l.push_back(rev8(v));
        send_bits(v, 8);
        #100;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_msb"}, data_m, 8'h00);
        check({tag, "_valid_msb"}, valid_m, 1'b0);
        check({tag, "_busy_msb"}, busy_m, 1'b0);
        check({tag, "_ovr_msb"}, ovr_m, 1'b0);
        check({tag, "_ferr_msb"}, ferr_m, 1'b0);
        check({tag, "_data_lsb"}, data_l, 8'h00);
        check({tag, "_valid_lsb"}, valid_l, 1'b0);
        check({tag, "_busy_lsb"}, busy_l, 1'b0);
    endtask

    initial begin
        int vc_m, vc_l, hs0;

        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        arstn_i = 1'b1;
        #100;

        // Basic frame with the consumer always ready.
        ready_i = 1'b1;
        ss_begin();
        send_byte(8'hA5);
        ss_end();
        check("a5_data_msb", data_m, 8'hA5);
        check("a5_data_lsb", data_l, 8'hA5);
        check("a5_handshakes", hs_m, 1);

        // Bit order: 0x3C and 0xA5 read the same either way, 0x01 does not.
        ss_begin();
        send_byte(8'h3C);
        ss_end();
        check("3c_data_lsb", data_l, 8'h3C);
        ss_begin();
        send_byte(8'h01);
        ss_end();
        check("01_data_msb", data_m, 8'h01);
        check("01_data_lsb", data_l, 8'h80);

        // Stalled consumer: second frame is dropped with an overrun pulse.
        ready_i = 1'b0;
        ss_begin();
        send_byte(8'h11);
        send_byte(8'h22);
        check("ovr_valid_msb", valid_m, 1'b1);
        check("ovr_data_msb", data_m, 8'h11);
        check("ovr_data_lsb", data_l, 8'h88);
        check("ovr_count_msb", obs_ovr_m, 1);
        check("ovr_count_lsb", obs_ovr_l, 1);
        @(posedge clk_i);
        #1 ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("ovr_valid_drop_msb", valid_m, 1'b0);
        check("ovr_valid_drop_lsb", valid_l, 1'b0);
        ss_end();

        // Aborted frame, then bus activity with select low, then a good frame.
        vc_m = valid_cyc_m;
        vc_l = valid_cyc_l;
        ss_begin();
        send_bits(8'hFF, 5);
        ss_end();
        send_bits(8'hB7, 8);
        #100;
        check("ferr_count_msb", obs_err_m, 1);
        check("ferr_count_lsb", obs_err_l, 1);
        check("ferr_no_valid_msb", valid_cyc_m - vc_m, 0);
        check("ferr_no_valid_lsb", valid_cyc_l - vc_l, 0);
        ss_begin();
        send_byte(8'h7E);
        ss_end();
        check("7e_data_msb", data_m, 8'h7E);

        // Reset in the middle of a frame.
        ss_begin();
        send_bits(8'hF0, 4);
        arstn_i = 1'b0;
        #1;
        check_all_zero("midreset");
        q_m.delete();
        q_l.delete();
        ss_i = 1'b0;
        #50;
        @(posedge clk_i);
        #1 arstn_i = 1'b1;
        #100;
        ss_begin();
        send_byte(8'h5A);
        ss_end();
        check("5a_data_msb", data_m, 8'h5A);
        check("5a_data_lsb", data_l, 8'h5A);

        // Back-to-back frames under one select.
        hs0 = hs_m;
        ss_begin();
        busy_chk = 1'b1;
        send_byte(8'h3C);
        send_byte(8'hC3);
        busy_chk = 1'b0;
        ss_end();
        check("b2b_handshakes", hs_m - hs0, 2);
        check("b2b_busy_low_cycles", busy_low, 0);
        check("b2b_data_msb", data_m, 8'hC3);
        check("b2b_data_lsb", data_l, 8'hC3);

        check("end_queue_msb", q_m.size(), 0);
        check("end_queue_lsb", q_l.size(), 0);
        check("end_ovr_msb", obs_ovr_m, exp_ovr);
        check("end_ovr_lsb", obs_ovr_l, exp_ovr);
        check("end_ferr_msb", obs_err_m, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_spi_slave_rx

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter DATA_W, default 8, bits per frame (legal 2..16).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on sclk_i/ss_i/mosi_i (legal 2..3).
REQ-003 Parameter MSB_FIRST, default 1; 1 = first received bit lands in data_o[DATA_W-1], 0 = in data_o[0].
REQ-004 Port list, one per line:
  clk_i  input  1  system clock, all logic on rising edge (single clock domain).
  arstn_i  input  1  reset, asynchronous, active-low.
  sclk_i  input  1  SPI serial clock from master, asynchronous to clk_i.
  ss_i  input  1  slave select, active-high, asynchronous.
  mosi_i  input  1  serial data from master, asynchronous.
  data_o  output  DATA_W  received frame, valid while valid_o=1.
  valid_o  output  1  frame available.
  ready_i  input  1  consumer accepts data_o when valid_o&ready_i.
  busy_o  output  1  frame in progress (state RECV).
  overrun_o  output  1  one-cycle pulse: completed frame dropped.
  frame_err_o  output  1  one-cycle pulse: ss_i dropped mid-frame.

Function
REQ-005 sclk_i, ss_i, mosi_i SHALL each pass through SYNC_STAGES flops before use; one further register per line gives edge detect (rise = s & ~d, fall = ~s & d).
REQ-006 Bits SHALL be sampled from synchronized mosi on synchronized sclk rise only (SPI mode 0); sclk fall is ignored.
REQ-007 Environment guarantee: sclk_i high and low phases each >= 2 clk_i periods; mosi_i stable across sclk_i rise; no behaviour is required otherwise.
REQ-008 FSM states IDLE, RECV, HOLD-free design: IDLE -> RECV on ss rise; RECV -> IDLE on ss fall or frame completion with ss low; RECV stays RECV across back-to-back frames while ss high.
REQ-009 On ss rise, bit counter SHALL clear to 0 and shift register to 0.
REQ-010 Each sampled bit SHALL increment counter; on the DATA_W-th bit counter wraps to 0 and frame completes.
REQ-011 Frame completion SHALL update data_o and assert valid_o on the clk_i edge after the sampling edge (latency 1 clk after sync rise detect).
REQ-012 valid_o SHALL stay high and data_o stable until a cycle with valid_o&ready_i; valid_o then deasserts next edge unless a new frame completes that same cycle.
REQ-013 Completion while valid_o=1 and ready_i=0: new frame dropped, data_o/valid_o unchanged, overrun_o pulses one cycle.
REQ-014 Completion while valid_o=1 and ready_i=1: new frame loaded, valid_o stays high, no overrun.
REQ-015 ss fall with counter != 0: partial bits discarded, frame_err_o pulses one cycle, no valid_o; ss fall with counter = 0: no error.
REQ-016 ss rise and sclk rise in same synchronized cycle: ss rise takes priority, bit not sampled.
REQ-017 busy_o = 1 exactly while state is RECV.
REQ-018 sclk/mosi activity while ss low SHALL be ignored.

Reset
REQ-019 arstn_i low SHALL immediately force: state IDLE, counter 0, shift register 0, synchronizer and edge flops 0, data_o 0, valid_o 0, busy_o 0, overrun_o 0, frame_err_o 0.
REQ-020 Reset mid-frame SHALL discard partial and pending data; first frame after release needs a fresh ss rise.
REQ-021 Reset deassertion is assumed synchronized externally to clk_i.

Structure
REQ-022 Package spi_pkg SHALL hold the FSM state enum and default DATA_W constant, shared with the SPI master.
REQ-023 Sub-module spi_sync (parameterized N-stage flop chain with async active-low reset) SHALL be instantiated once per input line.
REQ-024 Target size 120-400 RTL lines; no memories, no latches, no combinational path input-to-output.

Verification (clk_i 100 MHz, sclk 10 MHz unless stated)
REQ-025 Defaults, ready_i=1, send 0xA5 -> one valid_o pulse, data_o=0xA5, no error/overrun.
REQ-026 MSB_FIRST=0, send 0xA5 MSB-first on wire -> data_o=0xA5 bit-reversed = 0xA5 check replaced by 0x3C -> data_o=0x3C reversed = 0x3C; bench also sends 0x01 -> data_o=0x80.
REQ-027 ready_i=0, ss held high, send 0x11 then 0x22 -> data_o=0x11, valid_o high, overrun_o one pulse; then ready_i=1 -> valid_o drops after one cycle.
REQ-028 ss high, 5 bits sent, ss low -> frame_err_o one pulse, valid_o never high; then full frame 0x7E -> data_o=0x7E.
REQ-029 arstn_i low after 4 bits of 0xF0 -> all outputs 0 immediately; after release ss rise plus 0x5A -> data_o=0x5A.
REQ-030 ss held high, back-to-back 0x3C, 0xC3, ready_i=1 -> two valid handshakes, data 0x3C then 0xC3, busy_o high throughout.
